// File: rtl/teng_block_lock.sv
// 64b/66b block lock for one 10GBASE-R lane: sync-header lock FSM, gearbox slip and header statistics.
// Optional high-BER monitor is built when TENG_BLOCK_LOCK_HI_BER_EN is defined.
module teng_block_lock #(
    parameter int P_SH_WINDOW    = 64,
    parameter int P_SH_INVLD_MAX = 16,
    parameter int P_SLIP_WAIT    = 16,
    parameter int P_BER_WINDOW   = 40283
) (
    input  logic        rx_user_clk_i,
    input  logic        rx_fsm_reset_done_i,
    input  logic [1:0]  head_i,
    input  logic        head_valid_i,
    input  logic        cnt_clr_i,
    output logic        slip_o,
    output logic        block_lock_o,
    output logic        hi_ber_o,
    output logic        link_ok_o,
    output logic [15:0] invld_cnt_o
);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    localparam logic [6:0] SH_WIN  = 7'(P_SH_WINDOW);
    localparam logic [4:0] INV_MAX = 5'(P_SH_INVLD_MAX);
    localparam logic [7:0] SLIP_LD = 8'(P_SLIP_WAIT);

    state_t     state, state_nxt;
    logic [6:0] sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [4:0] sh_invld_cnt, sh_invld_cnt_nxt, sh_invld_inc;
    logic [7:0] slip_timer, slip_timer_nxt;
    logic       slip_nxt, lock_nxt;
    logic       hdr_ok, hdr_bad;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hdr_ok       = head_valid_i & (head_i[1] ^ head_i[0]);
    assign hdr_bad      = head_valid_i & ~(head_i[1] ^ head_i[0]);
    assign sh_cnt_inc   = sh_cnt + 7'd1;
    assign sh_invld_inc = sh_invld_cnt + {4'd0, hdr_bad};

    always_ff @(posedge rx_user_clk_i or negedge rx_fsm_reset_done_i) begin
        if (!rx_fsm_reset_done_i) begin
            state        <= HUNT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            slip_timer   <= '0;
            slip_o       <= 1'b0;
            block_lock_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            slip_timer   <= slip_timer_nxt;
            slip_o       <= slip_nxt;
            block_lock_o <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        slip_timer_nxt   = slip_timer;
        case (state)
            HUNT: begin
                if (hdr_bad) begin
                    state_nxt        = SLIP_WAIT;
                    sh_cnt_nxt       = '0;
                    sh_invld_cnt_nxt = '0;
                    slip_timer_nxt   = SLIP_LD;
                end else if (hdr_ok) begin
                    if (sh_cnt_inc == SH_WIN) begin
                        state_nxt        = LOCKED;
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_cnt_inc;
                    end
                end
            end
            // Gearbox settles after a slip; headers are not looked at here.
            SLIP_WAIT: begin
                if (slip_timer == 8'd0) state_nxt = HUNT;
                else                    slip_timer_nxt = slip_timer - 8'd1;
            end
            LOCKED: begin
                if (head_valid_i) begin
                    if (sh_invld_inc == INV_MAX) begin
                        state_nxt        = SLIP_WAIT;
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                        slip_timer_nxt   = SLIP_LD;
                    end else if (sh_cnt_inc == SH_WIN) begin
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt       = sh_cnt_inc;
                        sh_invld_cnt_nxt = sh_invld_inc;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        slip_nxt = (state != SLIP_WAIT) && (state_nxt == SLIP_WAIT);
        lock_nxt = (state_nxt == LOCKED);
    end

    always_ff @(posedge rx_user_clk_i or negedge rx_fsm_reset_done_i) begin
        if (!rx_fsm_reset_done_i)              invld_cnt_o <= '0;
        else if (cnt_clr_i)                    invld_cnt_o <= '0;
        else if ((state == LOCKED) && hdr_bad) invld_cnt_o <= sat_inc16(invld_cnt_o);
    end

`ifdef TENG_BLOCK_LOCK_HI_BER_EN
    localparam int BER_TW = $clog2(P_BER_WINDOW);

    logic [BER_TW-1:0] ber_timer;
    logic [4:0]        ber_cnt;
    logic              ber_wrap;

    function automatic logic [4:0] sat_inc_ber(input logic [4:0] v, input logic inc);
        return (v == 5'd16) ? v : v + {4'd0, inc};
    endfunction

    assign ber_wrap = (ber_timer == BER_TW'(P_BER_WINDOW - 1));

    // hi_ber is only re-evaluated while locked; an unlocked link keeps the last verdict.
    always_ff @(posedge rx_user_clk_i or negedge rx_fsm_reset_done_i) begin
        if (!rx_fsm_reset_done_i) begin
            ber_timer <= '0;
            ber_cnt   <= '0;
            hi_ber_o  <= 1'b0;
        end else begin
            ber_timer <= ber_wrap ? '0 : ber_timer + 1'b1;
            if (!block_lock_o) begin
                ber_cnt <= '0;
            end else if (ber_wrap) begin
                ber_cnt  <= '0;
                hi_ber_o <= (ber_cnt == 5'd16);
            end else begin
                ber_cnt <= sat_inc_ber(ber_cnt, hdr_bad);
                if (ber_cnt == 5'd16) hi_ber_o <= 1'b1;
            end
        end
    end
`else
    assign hi_ber_o = 1'b0;
`endif

    always_ff @(posedge rx_user_clk_i or negedge rx_fsm_reset_done_i) begin
        if (!rx_fsm_reset_done_i) link_ok_o <= 1'b0;
        else                      link_ok_o <= block_lock_o & ~hi_ber_o;
    end

endmodule
